cond_exec_unit: RTL and testbench
=================================

COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 Parameter FLAG_GROUPS, default 2, number of independent flag-write groups; legal values 1, 2, 4.
REQ-002 Parameter MAX_IT_LEN, default 4, maximum predicated slots per IT block; legal range 1..8.
REQ-003 Parameter ITLW, default $clog2(MAX_IT_LEN+1), width of IT length/remain fields.
REQ-004 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_Valid_E  in  1  E-stage instruction valid.
REQ-007 i_Stall_E  in  1  E stage held this cycle.
REQ-008 i_Flush_E  in  1  E-stage instruction squashed.
REQ-009 i_FlagWrite_E  in  FLAG_GROUPS  per-group flag write request.
REQ-010 i_Cond_E  in  4  instruction condition field.
REQ-011 i_ALUFlags  in  4  ALU result flags {N,Z,C,V}.
REQ-012 i_ITStart_E  in  1  instruction is an IT-block opener.
REQ-013 i_ITCond_E  in  4  IT base condition.
REQ-014 i_ITMask_E  in  MAX_IT_LEN-1  bit k-1 governs slot k (k>=1): 1 = base, 0 = inverse.
REQ-015 i_ITLen_E  in  ITLW  number of predicated slots.
REQ-016 o_Flags  out  4  architectural flag register {N,Z,C,V}.
REQ-017 o_CondEx_E  out  1  E-stage instruction executes.
REQ-018 o_EffCond_E  out  4  condition actually evaluated this cycle.
REQ-019 o_ITActive  out  1  IT block in progress.
REQ-020 o_ITRemain  out  ITLW  slots still to be consumed.

Function
REQ-021 Condition evaluation SHALL be combinational against registered o_Flags: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 1.
REQ-022 o_EffCond_E SHALL be the current slot condition when o_ITActive=1, else i_Cond_E.
REQ-023 Slot condition: slot 0 = base; slot k = base if mask[k-1]=1, else base with bit 0 inverted.
REQ-024 o_CondEx_E = i_Valid_E & !i_Flush_E & eval(o_EffCond_E); 0 while i_Valid_E=0.
REQ-025 Group g SHALL cover flag bits [(g+1)*4/FLAG_GROUPS-1 : g*4/FLAG_GROUPS]; FLAG_GROUPS=2: group 1 = N,Z, group 0 = C,V.
REQ-026 On a clock edge with o_CondEx_E=1 and i_Stall_E=0, each group with i_FlagWrite_E[g]=1 SHALL load the corresponding i_ALUFlags bits; all other bits hold.
REQ-027 Flag update latency: 1 cycle; the next instruction evaluates against the updated flags.
REQ-028 IT FSM states: IDLE, ACTIVE.
REQ-029 IDLE->ACTIVE on an accepted instruction (Valid & !Stall & !Flush) with i_ITStart_E=1 and 1<=i_ITLen_E<=MAX_IT_LEN; latch base, mask, remain=i_ITLen_E, slot=0.
REQ-030 IT opener with i_ITLen_E=0 or >MAX_IT_LEN SHALL be ignored; stay IDLE.
REQ-031 ACTIVE: each accepted instruction SHALL consume one slot (remain-1, slot+1), whether or not it executes.
REQ-032 ACTIVE->IDLE when the slot with remain=1 is consumed; remain=0, slot=0.
REQ-033 i_ITStart_E while ACTIVE SHALL be ignored as an opener; the instruction consumes a slot normally.
REQ-034 i_Flush_E=1 SHALL force o_CondEx_E=0, block flag writes, and force IDLE (remain=0) on the next edge, regardless of i_Stall_E.
REQ-035 i_Stall_E=1 without flush SHALL hold flags, FSM, remain and slot unchanged.
REQ-036 o_ITActive=1 exactly in ACTIVE; o_ITRemain reflects registered remain.

Reset
REQ-037 i_reset=1 SHALL immediately set o_Flags=4'b0000, FSM=IDLE, o_ITRemain=0, slot=0, independent of i_clk.
REQ-038 Reset asserted mid-IT-block SHALL abort it; first instruction after release evaluates i_Cond_E against flags 0000.

Verification
REQ-039 Reset, then Cond=EQ (0000), Valid=1 -> CondEx=0; ALUFlags=0100, FlagWrite=2'b10, Cond=AL -> next cycle Flags=0100, EQ then gives CondEx=1.
REQ-040 Flags=0000, FlagWrite=2'b01, ALUFlags=1111, Cond=AL -> Flags=0011 (N,Z untouched).
REQ-041 Flags=0100, IT opener base=EQ, Len=3, mask=2'b10 -> slots EQ, NE, EQ -> CondEx 1,0,1; Remain 3,2,1; IDLE after third.
REQ-042 IT active, Remain=2, Stall=1 for 2 cycles -> Remain stays 2, Flags unchanged; then Flush=1 -> CondEx=0, next cycle ITActive=0, Remain=0.
REQ-043 IT active with Remain=2, async reset pulse between clock edges -> Flags=0000, ITActive=0 immediately.
REQ-044 IT opener with Len=0, then Cond=NE with Flags=0000 -> ITActive stays 0, CondEx=1.

Source files
------------

// File: rtl/cond_exec_unit.sv
// Conditional-execution unit: architectural NZCV flags, condition evaluation and
// an IT-block sequencer that supplies per-slot predicates to the E stage.
module cond_exec_unit #(
  parameter int FLAG_GROUPS = 2,
  parameter int MAX_IT_LEN  = 4,
  parameter int ITLW        = $clog2(MAX_IT_LEN + 1),
  localparam int MW         = (MAX_IT_LEN > 1) ? MAX_IT_LEN - 1 : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_Valid_E,
  input  logic                   i_Stall_E,
  input  logic                   i_Flush_E,
  input  logic [FLAG_GROUPS-1:0] i_FlagWrite_E,
  input  logic [3:0]             i_Cond_E,
  input  logic [3:0]             i_ALUFlags,
  input  logic                   i_ITStart_E,
  input  logic [3:0]             i_ITCond_E,
  input  logic [MW-1:0]          i_ITMask_E,
  input  logic [ITLW-1:0]        i_ITLen_E,
  output logic [3:0]             o_Flags,
  output logic                   o_CondEx_E,
  output logic [3:0]             o_EffCond_E,
  output logic                   o_ITActive,
  output logic [ITLW-1:0]        o_ITRemain
);

  localparam int GW = 4 / FLAG_GROUPS;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } itState_t;

  itState_t        r_state;
  logic [3:0]      r_flags;
  logic [3:0]      r_base;
  logic [MW-1:0]   r_mask;
  logic [ITLW-1:0] r_remain;
  logic [ITLW-1:0] r_slot;

  logic            w_maskBit;
  logic [3:0]      w_slotCond;
  logic [3:0]      w_effCond;
  logic            w_condEx;
  logic            w_accept;
  logic            w_flagWe;
  logic            w_lenOk;
  logic [3:0]      w_writeMask;

  function automatic logic evalCond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'h0:    evalCond = z;
      4'h1:    evalCond = !z;
      4'h2:    evalCond = cf;
      4'h3:    evalCond = !cf;
      4'h4:    evalCond = n;
      4'h5:    evalCond = !n;
      4'h6:    evalCond = v;
      4'h7:    evalCond = !v;
      4'h8:    evalCond = cf & !z;
      4'h9:    evalCond = !cf | z;
      4'hA:    evalCond = (n == v);
      4'hB:    evalCond = (n != v);
      4'hC:    evalCond = !z & (n == v);
      4'hD:    evalCond = z | (n != v);
      default: evalCond = 1'b1;
    endcase
  endfunction

  // Slot 0 always uses the base condition; later slots pick base or inverse from the mask.
  always_comb begin
    w_maskBit = 1'b1;
    for (int k = 1; k < MAX_IT_LEN; k++) begin
      if (r_slot == ITLW'(k)) w_maskBit = r_mask[k-1];
    end
    w_slotCond = w_maskBit ? r_base : {r_base[3:1], ~r_base[0]};
  end

  assign w_effCond = (r_state == ACTIVE) ? w_slotCond : i_Cond_E;
  assign w_condEx  = i_Valid_E & !i_Flush_E & evalCond(w_effCond, r_flags);
  assign w_accept  = i_Valid_E & !i_Stall_E & !i_Flush_E;
  assign w_flagWe  = w_condEx & !i_Stall_E;
  assign w_lenOk   = (i_ITLen_E != '0) && (i_ITLen_E <= ITLW'(MAX_IT_LEN));

  for (genvar g = 0; g < FLAG_GROUPS; g++) begin : g_wmask
    assign w_writeMask[(g+1)*GW-1 : g*GW] = {GW{i_FlagWrite_E[g]}};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_flags <= 4'b0000;
    end else if (w_flagWe) begin
      r_flags <= (r_flags & ~w_writeMask) | (i_ALUFlags & w_writeMask);
    end
  end

  // Flush wins over stall so a squashed IT block never resumes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_remain <= '0;
      r_slot   <= '0;
      r_base   <= '0;
      r_mask   <= '0;
    end else if (i_Flush_E) begin
      r_state  <= IDLE;
      r_remain <= '0;
      r_slot   <= '0;
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (i_ITStart_E && w_lenOk) begin
            r_state  <= ACTIVE;
            r_base   <= i_ITCond_E;
            r_mask   <= i_ITMask_E;
            r_remain <= i_ITLen_E;
            r_slot   <= '0;
          end
        end
        ACTIVE: begin
          if (r_remain == ITLW'(1)) begin
            r_state  <= IDLE;
            r_remain <= '0;
            r_slot   <= '0;
          end else begin
            r_remain <= r_remain - ITLW'(1);
            r_slot   <= r_slot + ITLW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_Flags     = r_flags;
  assign o_CondEx_E  = w_condEx;
  assign o_EffCond_E = w_effCond;
  assign o_ITActive  = (r_state == ACTIVE);
  assign o_ITRemain  = r_remain;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Bench for cond_exec_unit: directed scenarios plus random traffic, checked against
// a queue-of-slot-conditions model of flags and IT blocks.
module tb_cond_exec_unit;

  localparam int FG   = 2;
  localparam int MAXL = 4;
  localparam int ITLW = 3;

  localparam logic [3:0] EQ = 4'h0;
  localparam logic [3:0] NE = 4'h1;
  localparam logic [3:0] AL = 4'hE;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid, stall, flush;
  logic [FG-1:0]   flagWrite;
  logic [3:0]      cond, aluFlags;
  logic            itStart;
  logic [3:0]      itCond;
  logic [MAXL-2:0] itMask;
  logic [ITLW-1:0] itLen;
  logic [3:0]      flagsOut;
  logic            condEx;
  logic [3:0]      effCond;
  logic            itActive;
  logic [ITLW-1:0] itRemain;

  int nAssert = 0;
  int nFail   = 0;

  logic [3:0] mFlags;
  logic [3:0] mQ[$];

  cond_exec_unit #(.FLAG_GROUPS(FG), .MAX_IT_LEN(MAXL), .ITLW(ITLW)) dut (
    .i_clk(clk), .i_reset(rst), .i_Valid_E(valid), .i_Stall_E(stall),
    .i_Flush_E(flush), .i_FlagWrite_E(flagWrite), .i_Cond_E(cond),
    .i_ALUFlags(aluFlags), .i_ITStart_E(itStart), .i_ITCond_E(itCond),
    .i_ITMask_E(itMask), .i_ITLen_E(itLen), .o_Flags(flagsOut),
    .o_CondEx_E(condEx), .o_EffCond_E(effCond), .o_ITActive(itActive),
    .o_ITRemain(itRemain)
  );

  always #5 clk = ~clk;

  function automatic bit refEval(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic [3:0] expEff;
    expEff = (mQ.size() > 0) ? mQ[0] : cond;
    checkOutput("effcond", {4'h0, effCond}, {4'h0, expEff});
    checkOutput("condex", {7'h0, condEx}, {7'h0, valid && !flush && refEval(expEff, mFlags)});
    checkOutput("flags", {4'h0, flagsOut}, {4'h0, mFlags});
    checkOutput("itactive", {7'h0, itActive}, {7'h0, mQ.size() > 0});
    checkOutput("itremain", {5'h0, itRemain}, 8'(mQ.size()));
  endtask

  task automatic advanceModel();
    logic [3:0] expEff;
    bit ex;
    expEff = (mQ.size() > 0) ? mQ[0] : cond;
    ex = valid && !flush && refEval(expEff, mFlags);
    if (flush) begin
      mQ.delete();
    end else if (!stall) begin
      if (ex)
        for (int b = 0; b < 4; b++)
          if (flagWrite[b * FG / 4]) mFlags[b] = aluFlags[b];
      if (valid) begin
        if (mQ.size() > 0) begin
          void'(mQ.pop_front());
        end else if (itStart && itLen >= 1 && itLen <= MAXL) begin
          mQ.push_back(itCond);
          for (int k = 1; k < int'(itLen); k++)
            mQ.push_back(itMask[k-1] ? itCond : (itCond ^ 4'b0001));
        end
      end
    end
  endtask

  task automatic driveIdle();
    valid = 0; stall = 0; flush = 0; flagWrite = '0; cond = AL; aluFlags = '0;
    itStart = 0; itCond = '0; itMask = '0; itLen = '0;
  endtask

  task automatic applyStimulus(input logic v, input logic st, input logic fl,
                               input logic [FG-1:0] fw, input logic [3:0] c,
                               input logic [3:0] alu, input logic its,
                               input logic [3:0] itc, input logic [MAXL-2:0] itm,
                               input logic [ITLW-1:0] itl);
    @(negedge clk);
    valid = v; stall = st; flush = fl; flagWrite = fw; cond = c; aluFlags = alu;
    itStart = its; itCond = itc; itMask = itm; itLen = itl;
    #1;
    checkAll();
    advanceModel();
  endtask

  initial begin
    driveIdle();
    rst = 1'b1;
    mFlags = 4'b0000;
    mQ.delete();
    #1;
    checkOutput("reset_flags", {4'h0, flagsOut}, 8'h00);
    checkOutput("reset_itactive", {7'h0, itActive}, 8'h00);
    checkOutput("reset_itremain", {5'h0, itRemain}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Flag load through group 1 then EQ sees Z
    applyStimulus(1, 0, 0, 2'b00, EQ, 4'b0000, 0, 0, 0, 0);
    checkOutput("req039_eq_before", {7'h0, condEx}, 8'h00);
    applyStimulus(1, 0, 0, 2'b10, AL, 4'b0100, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, EQ, 4'b0000, 0, 0, 0, 0);
    checkOutput("req039_flags", {4'h0, flagsOut}, 8'h04);
    checkOutput("req039_eq_after", {7'h0, condEx}, 8'h01);

    // Group 0 only touches C,V
    applyStimulus(1, 0, 0, 2'b11, AL, 4'b0000, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'b01, AL, 4'b1111, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 2'b00, AL, 4'b0000, 0, 0, 0, 0);
    checkOutput("req040_flags", {4'h0, flagsOut}, 8'h03);

    // IT block EQ/NE/EQ with Z set
    applyStimulus(1, 0, 0, 2'b11, AL, 4'b0100, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, AL, 4'b0000, 1, EQ, 3'b010, 3);
    applyStimulus(1, 0, 0, 2'b00, AL, 4'b0000, 0, 0, 0, 0);
    checkOutput("req041_ex0", {7'h0, condEx}, 8'h01);
    checkOutput("req041_rem0", {5'h0, itRemain}, 8'h03);
    applyStimulus(1, 0, 0, 2'b00, AL, 4'b0000, 0, 0, 0, 0);
    checkOutput("req041_ex1", {7'h0, condEx}, 8'h00);
    checkOutput("req041_eff1", {4'h0, effCond}, {4'h0, NE});
    checkOutput("req041_rem1", {5'h0, itRemain}, 8'h02);
    applyStimulus(1, 0, 0, 2'b00, AL, 4'b0000, 0, 0, 0, 0);
    checkOutput("req041_ex2", {7'h0, condEx}, 8'h01);
    checkOutput("req041_rem2", {5'h0, itRemain}, 8'h01);
    applyStimulus(0, 0, 0, 2'b00, AL, 4'b0000, 0, 0, 0, 0);
    checkOutput("req041_idle", {7'h0, itActive}, 8'h00);

    // Stall holds IT state, flush aborts it and blocks the flag write
    applyStimulus(1, 0, 0, 2'b00, AL, 4'b0000, 1, EQ, 3'b111, 3);
    applyStimulus(1, 0, 0, 2'b00, AL, 4'b0000, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 2'b11, AL, 4'b1011, 0, 0, 0, 0);
    checkOutput("req042_stall_rem", {5'h0, itRemain}, 8'h02);
    applyStimulus(1, 1, 0, 2'b11, AL, 4'b1011, 0, 0, 0, 0);
    checkOutput("req042_stall_rem2", {5'h0, itRemain}, 8'h02);
    checkOutput("req042_stall_flags", {4'h0, flagsOut}, 8'h04);
    applyStimulus(1, 0, 1, 2'b11, AL, 4'b1011, 0, 0, 0, 0);
    checkOutput("req042_flush_ex", {7'h0, condEx}, 8'h00);
    applyStimulus(0, 0, 0, 2'b00, AL, 4'b0000, 0, 0, 0, 0);
    checkOutput("req042_post_active", {7'h0, itActive}, 8'h00);
    checkOutput("req042_post_rem", {5'h0, itRemain}, 8'h00);
    checkOutput("req042_post_flags", {4'h0, flagsOut}, 8'h04);

    // Asynchronous reset in the middle of an IT block
    applyStimulus(1, 0, 0, 2'b00, AL, 4'b0000, 1, EQ, 3'b111, 3);
    applyStimulus(1, 0, 0, 2'b00, AL, 4'b0000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("req043_pre_rem", {5'h0, itRemain}, 8'h02);
    driveIdle();
    #1;
    rst = 1'b1;
    mFlags = 4'b0000;
    mQ.delete();
    #1;
    checkOutput("req043_flags", {4'h0, flagsOut}, 8'h00);
    checkOutput("req043_itactive", {7'h0, itActive}, 8'h00);
    checkOutput("req043_itremain", {5'h0, itRemain}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 0, 0, 2'b00, NE, 4'b0000, 0, 0, 0, 0);
    checkOutput("req038_ne_ex", {7'h0, condEx}, 8'h01);
    checkOutput("req038_eff", {4'h0, effCond}, {4'h0, NE});

    // Illegal IT lengths are ignored
    applyStimulus(1, 0, 0, 2'b00, AL, 4'b0000, 1, EQ, 3'b000, 0);
    applyStimulus(1, 0, 0, 2'b00, NE, 4'b0000, 0, 0, 0, 0);
    checkOutput("req044_itactive", {7'h0, itActive}, 8'h00);
    checkOutput("req044_ex", {7'h0, condEx}, 8'h01);
    applyStimulus(1, 0, 0, 2'b00, AL, 4'b0000, 1, EQ, 3'b000, 5);
    applyStimulus(0, 0, 0, 2'b00, AL, 4'b0000, 0, 0, 0, 0);
    checkOutput("len5_itactive", {7'h0, itActive}, 8'h00);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic            rv, rs, rf, ri;
      logic [FG-1:0]   rfw;
      logic [3:0]      rc, ra, ric;
      logic [MAXL-2:0] rm;
      logic [ITLW-1:0] rl;
      rv  = ($urandom_range(0, 9) < 8);
      rs  = ($urandom_range(0, 9) < 2);
      rf  = ($urandom_range(0, 19) < 2);
      ri  = ($urandom_range(0, 3) == 0);
      rfw = FG'($urandom_range(0, 3));
      rc  = 4'($urandom);
      ra  = 4'($urandom);
      ric = 4'($urandom);
      rm  = (MAXL-1)'($urandom);
      rl  = ITLW'($urandom_range(0, 6));
      applyStimulus(rv, rs, rf, rfw, rc, ra, ri, ric, rm, rl);
    end
    applyStimulus(0, 0, 0, 2'b00, AL, 4'b0000, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
